// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO bank: register map and the bus-side data width.
package gpio_pkg;

    localparam int MAX_WIDTH = 16;

    typedef enum logic [2:0] {
        REG_DATA    = 3'd0,
        REG_DIR     = 3'd1,
        REG_SET     = 3'd2,
        REG_CLR     = 3'd3,
        REG_TOG     = 3'd4,
        REG_RISE_EN = 3'd5,
        REG_FALL_EN = 3'd6,
        REG_EVENT   = 3'd7
    } reg_sel_e;

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage input synchroniser with a one-cycle history register and
// single-cycle rise/fall pulses derived from the synchronised pin state.
module gpio_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stg_q;
    logic [WIDTH-1:0]                  prev_q;

    // Shift the raw pads through the synchroniser chain and remember last cycle's state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg_q  <= '0;
            prev_q <= '0;
        end else begin
            stg_q[0] <= pin_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stg_q[i] <= stg_q[i-1];
            end
            prev_q <= stg_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = stg_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~prev_q;
    assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: output latch with atomic set/clear/toggle, direction
// register, synchronised inputs, sticky per-pin edge events and an irq line.
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int             WIDTH       = 8,
    parameter int             SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_OUT = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_wr,
    input  logic                 io_rd,
    input  logic [2:0]           reg_sel,
    input  logic [MAX_WIDTH-1:0] wd,
    output logic [MAX_WIDTH-1:0] rd,
    input  logic [WIDTH-1:0]     pin_in,
    output logic [WIDTH-1:0]     pin_out,
    output logic                 pin_oe_unused_guard,
    output logic [WIDTH-1:0]     pin_oe,
    output logic                 irq
);

    logic [WIDTH-1:0]     out_q, out_d;
    logic [WIDTH-1:0]     dir_q, dir_d;
    logic [WIDTH-1:0]     rise_en_q, rise_en_d;
    logic [WIDTH-1:0]     fall_en_q, fall_en_d;
    logic [WIDTH-1:0]     event_q, event_d;
    logic [MAX_WIDTH-1:0] rd_q, rd_d;
    logic                 irq_q, irq_d;

    logic [WIDTH-1:0]     wd_w;
    logic [WIDTH-1:0]     clr_mask;
    logic [WIDTH-1:0]     rd_val;
    logic [WIDTH-1:0]     pin_s, pin_rise, pin_fall;
    logic                 unused_wd_hi;

    // Upper write-data bits beyond the bank width carry no meaning.
    assign wd_w         = wd[WIDTH-1:0];
    assign unused_wd_hi = ^(wd >> WIDTH);

    gpio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .pin_in (pin_in),
        .sync_o (pin_s),
        .rise_o (pin_rise),
        .fall_o (pin_fall)
    );

    // Decode writes into next-state values; hardware event sets take priority over clears.
    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr_mask  = '0;
        if (io_wr) begin
            case (reg_sel)
                REG_DATA:    out_d     = wd_w;
                REG_DIR:     dir_d     = wd_w;
                REG_SET:     out_d     = out_q | wd_w;
                REG_CLR:     out_d     = out_q & ~wd_w;
                REG_TOG:     out_d     = out_q ^ wd_w;
                REG_RISE_EN: rise_en_d = wd_w;
                REG_FALL_EN: fall_en_d = wd_w;
                REG_EVENT:   clr_mask  = wd_w;
                default:     ;
            endcase
        end
        event_d = (event_q & ~clr_mask) | (pin_rise & rise_en_q) | (pin_fall & fall_en_q);
        irq_d   = |event_d;
    end

    // Read mux samples current (pre-write) register state; rd holds until the next read.
    always_comb begin
        rd_val = '0;
        case (reg_sel)
            REG_DATA:    rd_val = pin_s;
            REG_DIR:     rd_val = dir_q;
            REG_SET:     rd_val = out_q;
            REG_CLR:     rd_val = out_q;
            REG_TOG:     rd_val = out_q;
            REG_RISE_EN: rd_val = rise_en_q;
            REG_FALL_EN: rd_val = fall_en_q;
            REG_EVENT:   rd_val = event_q;
            default:     rd_val = '0;
        endcase
        rd_d = io_rd ? MAX_WIDTH'(rd_val) : rd_q;
    end

    // All architectural state, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q     <= RESET_OUT;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            event_q   <= '0;
            rd_q      <= '0;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            event_q   <= event_d;
            rd_q      <= rd_d;
            irq_q     <= irq_d;
        end
    end

    assign pin_out             = out_q;
    assign pin_oe              = dir_q;
    assign rd                  = rd_q;
    assign irq                 = irq_q;
    assign pin_oe_unused_guard = 1'b0;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed-vector bench for gpio_bank: an 8-bit instance with a non-zero
// reset latch and a 12-bit instance, both driven from one shared IO bus.
module tb_gpio_bank;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        io_wr = 1'b0;
    logic        io_rd = 1'b0;
    logic [2:0]  reg_sel = 3'd0;
    logic [15:0] wd = 16'h0000;

    logic [15:0] rd8, rd12;
    logic [7:0]  pin_in8 = 8'h00, pin_out8, pin_oe8;
    logic [11:0] pin_in12 = 12'h000, pin_out12, pin_oe12;
    logic        irq8, irq12;
    logic        g8, g12;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gpio_bank #(.WIDTH(8), .SYNC_STAGES(2), .RESET_OUT(8'hA5)) u_dut8 (
        .clk(clk), .reset(reset), .io_wr(io_wr), .io_rd(io_rd), .reg_sel(reg_sel),
        .wd(wd), .rd(rd8), .pin_in(pin_in8), .pin_out(pin_out8),
        .pin_oe_unused_guard(g8), .pin_oe(pin_oe8), .irq(irq8)
    );

    gpio_bank #(.WIDTH(12), .SYNC_STAGES(2)) u_dut12 (
        .clk(clk), .reset(reset), .io_wr(io_wr), .io_rd(io_rd), .reg_sel(reg_sel),
        .wd(wd), .rd(rd12), .pin_in(pin_in12), .pin_out(pin_out12),
        .pin_oe_unused_guard(g12), .pin_oe(pin_oe12), .irq(irq12)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
        end
    endtask

    // Tasks are entered just after a negedge and return at a later negedge.
    task automatic wr(input logic [2:0] sel, input logic [15:0] data);
        io_wr = 1'b1; reg_sel = sel; wd = data;
        @(negedge clk);
        io_wr = 1'b0; wd = 16'h0000;
    endtask

    task automatic rdreg(input logic [2:0] sel);
        io_rd = 1'b1; reg_sel = sel;
        @(negedge clk);
        io_rd = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values while reset is held
        idle(3);
        check("rst_out8", pin_out8, 16'h00A5);
        check("rst_oe8", pin_oe8, 16'h0000);
        check("rst_irq8", irq8, 16'h0000);
        check("rst_rd8", rd8, 16'h0000);
        check("rst_out12", pin_out12, 16'h0000);
        reset = 1'b0;
        idle(1);

        // Atomic latch writes
        wr(3'd0, 16'h000F);
        check("data_out8", pin_out8, 16'h000F);
        wr(3'd2, 16'h0030);
        check("set_out8", pin_out8, 16'h003F);
        wr(3'd3, 16'h0005);
        check("clr_out8", pin_out8, 16'h003A);
        wr(3'd4, 16'h00FF);
        check("tog_out8", pin_out8, 16'h00C5);
        check("tog_out12", pin_out12, 16'h00C5);
        wr(3'd2, 16'h0000);
        wr(3'd3, 16'h0000);
        wr(3'd4, 16'h0000);
        check("zero_wd_out8", pin_out8, 16'h00C5);
        rdreg(3'd2);
        check("rd_set8", rd8, 16'h00C5);
        rdreg(3'd4);
        check("rd_tog12", rd12, 16'h00C5);

        // Rising edge on pin 0: flag appears on the third edge
        wr(3'd5, 16'h0001);
        pin_in8[0] = 1'b1;
        idle(1);
        check("rise_lat1_irq", irq8, 16'h0000);
        idle(1);
        check("rise_lat2_irq", irq8, 16'h0000);
        idle(1);
        check("rise_lat3_irq", irq8, 16'h0001);
        rdreg(3'd7);
        check("rise_event", rd8, 16'h0001);

        // Clear, then a falling edge with FALL_EN=0 stays silent
        wr(3'd7, 16'h0001);
        check("clr_irq", irq8, 16'h0000);
        pin_in8[0] = 1'b0;
        idle(5);
        check("fall_off_irq", irq8, 16'h0000);
        rdreg(3'd7);
        check("fall_off_event", rd8, 16'h0000);

        // Clear collides with a rising edge at the detector: set wins
        pin_in8[0] = 1'b1;
        idle(2);
        wr(3'd7, 16'h0001);
        check("collide_irq", irq8, 16'h0001);
        rdreg(3'd7);
        check("collide_event", rd8, 16'h0001);
        wr(3'd7, 16'h0001);
        check("quiet_clr_irq", irq8, 16'h0000);
        rdreg(3'd7);
        check("quiet_clr_event", rd8, 16'h0000);

        // Falling edge captured when enabled; disabling keeps the flag
        wr(3'd6, 16'h0001);
        pin_in8[0] = 1'b0;
        idle(3);
        check("fall_on_irq", irq8, 16'h0001);
        wr(3'd6, 16'h0000);
        wr(3'd5, 16'h0000);
        idle(2);
        rdreg(3'd7);
        check("en_off_keeps", rd8, 16'h0001);
        wr(3'd7, 16'hFFFF);
        check("clr_all_irq", irq8, 16'h0000);

        // Read and write of DIR in the same cycle returns the old value
        io_rd = 1'b1;
        wr(3'd1, 16'h0055);
        io_rd = 1'b0;
        check("rw_rd_old", rd8, 16'h0000);
        check("rw_oe8", pin_oe8, 16'h0055);

        // Width masking on the 12-bit bank
        wr(3'd1, 16'hFFFF);
        check("dir_oe12", pin_oe12, 16'h0FFF);
        check("dir_oe8", pin_oe8, 16'h00FF);
        rdreg(3'd1);
        check("dir_rd12", rd12, 16'h0FFF);
        check("dir_rd8", rd8, 16'h00FF);

        // Synchronised DATA read, valid next cycle and held
        pin_in12 = 12'hABC;
        idle(4);
        rdreg(3'd0);
        check("data_rd12", rd12, 16'h0ABC);
        pin_in12 = 12'h123;
        idle(4);
        check("data_hold12", rd12, 16'h0ABC);

        // Async reset mid-operation
        wr(3'd0, 16'h00FF);
        wr(3'd5, 16'h0080);
        pin_in8[7] = 1'b1;
        idle(4);
        rdreg(3'd7);
        check("pre_rst_event", rd8, 16'h0080);
        check("pre_rst_out", pin_out8, 16'h00FF);
        #2;
        reset = 1'b1;
        #1;
        check("arst_out8", pin_out8, 16'h00A5);
        check("arst_oe8", pin_oe8, 16'h0000);
        check("arst_irq8", irq8, 16'h0000);
        check("arst_rd8", rd8, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        // Released with pad 7 high: pin state follows, no event
        idle(5);
        check("rel_irq8", irq8, 16'h0000);
        rdreg(3'd0);
        check("rel_data8", rd8, 16'h0080);
        rdreg(3'd7);
        check("rel_event8", rd8, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
